charis_mc_control: RTL

Multicycle control FSM that sequences the fetch, decode/register-file, ALU and memory datapath for one instruction at a time. It decodes the 6-bit opcode held in the instruction register and drives the register-file write, write-data and operand-select controls, the ALU function and operand select, the PC/IR load enables and a request/acknowledge handshake to data memory. It sits at the top level beside the datapath stages and owns every state-dependent enable in the processor.

---
 rtl/charis_mc_control.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/charis_mc_control.sv
// charis_mc_control
//   Multicycle control FSM for the CHARIS datapath. It runs one instruction
//   at a time through IF -> DEC -> EX -> MEM -> WB. It decodes Instr[31:26]
//   and drives every state-dependent enable in the processor.
//
//   Ports
//     Clk, Rst_n     rising-edge clock; asynchronous active-low reset
//     Instr          IR contents; only the opcode and Instr[3:0] are used
//     ALU_zero       ALU zero flag, used by beq/bne in EX
//     MEM_ack        data memory access complete
//     PC_LdEn/PC_sel PC load and next-PC select (0 = PC+4, 1 = branch target)
//     IR_LdEn        instruction register load
//     RF_WrEn, RF_WrData_sel, RF_B_sel
//                    register file write enable, write-data select and
//                    second read-address select
//     ALU_Bin_sel, ALU_func
//                    ALU operand-B select and operation code
//     MEM_req, MEM_WrEn, ByteOp
//                    data memory request, store strobe and byte access
//     Illegal, MemFault
//                    one-cycle pulses: unknown opcode, memory timeout
//
//   ALU function codes used here: add 0000, sub 0001, and 0010, or 0011.
module charis_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        MEM_ack,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_req,
  output logic        MEM_WrEn,
  output logic        ByteOp,
  output logic        Illegal,
  output logic        MemFault
);

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IF,
    S_DEC,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;

  logic [5:0] opcode;
  logic       is_rtype, is_imm, is_jmp, is_beq, is_bne;
  logic       is_load, is_store, is_byte, is_illegal;
  logic [3:0] imm_func;

  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:4];

  assign opcode = Instr[31:26];

  // Opcode classification
  always_comb begin
    is_rtype   = 1'b0;
    is_imm     = 1'b0;
    is_jmp     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_byte    = 1'b0;
    is_illegal = 1'b0;
    imm_func   = ALU_ADD;
    case (opcode)
      OP_RTYPE: is_rtype = 1'b1;
      OP_ADDI,
      OP_LI,
      OP_LUI:   is_imm   = 1'b1;
      OP_ANDI: begin
        is_imm   = 1'b1;
        imm_func = ALU_AND;
      end
      OP_ORI: begin
        is_imm   = 1'b1;
        imm_func = ALU_OR;
      end
      OP_B:     is_jmp   = 1'b1;
      OP_BEQ:   is_beq   = 1'b1;
      OP_BNE:   is_bne   = 1'b1;
      OP_LW:    is_load  = 1'b1;
      OP_LB: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      OP_SW:    is_store = 1'b1;
      OP_SB: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      default:  is_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IF;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == S_MEM && state_nxt == S_MEM) ? wait_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    MEM_req       = 1'b0;
    MEM_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    MemFault      = 1'b0;
    case (state)
      S_IF: begin
        // The state register sits in IF while reset is held; gate the load
        // so the IR is not written until reset is released.
        IR_LdEn   = Rst_n;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        RF_B_sel = is_store | is_beq | is_bne;
        if (is_illegal) begin
          Illegal   = 1'b1;
          PC_LdEn   = 1'b1;
          state_nxt = S_IF;
        end else if (is_jmp) begin
          PC_LdEn   = 1'b1;
          PC_sel    = 1'b1;
          state_nxt = S_IF;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_rtype) begin
          ALU_func  = Instr[3:0];
          state_nxt = S_WB;
        end else if (is_imm) begin
          ALU_Bin_sel = 1'b1;
          ALU_func    = imm_func;
          state_nxt   = S_WB;
        end else if (is_beq | is_bne) begin
          ALU_func  = ALU_SUB;
          PC_LdEn   = 1'b1;
          PC_sel    = is_beq ? ALU_zero : !ALU_zero;
          state_nxt = S_IF;
        end else if (is_load | is_store) begin
          ALU_Bin_sel = 1'b1;
          state_nxt   = S_MEM;
        end else begin
          state_nxt = S_IF;
        end
      end
      S_MEM: begin
        MEM_req  = 1'b1;
        MEM_WrEn = is_store;
        ByteOp   = is_byte;
        // An ack in the timeout cycle still wins over the fault.
        if (MEM_ack) begin
          if (is_store) begin
            PC_LdEn   = 1'b1;
            state_nxt = S_IF;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_cnt == TIMEOUT_CNT) begin
          MEM_req   = 1'b0;
          MEM_WrEn  = 1'b0;
          ByteOp    = 1'b0;
          MemFault  = 1'b1;
          PC_LdEn   = 1'b1;
          state_nxt = S_IF;
        end
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = is_load;
        PC_LdEn       = 1'b1;
        state_nxt     = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule
